exhaustive_bist: RTL and testbench

- Parametrised built-in self-test controller for combinational lab blocks.
- Sequences all 2^N_IN input vectors into a DUT, holding each vector for HOLD cycles.
- Compresses the DUT responses into a MISR signature and compares it against a golden value.
- Successor to hand-written exhaustive truth-table benches: it is synthesisable, self-checking, and width/hold-configurable.

---
 rtl/exhaustive_bist.sv | 109 ++++++++++
 tb/tb_exhaustive_bist.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_bist.sv
// Exhaustive BIST controller: sweeps every input vector into a combinational
// block, folds its responses into a MISR and compares against a golden signature.
//
// state | meaning
// IDLE  | waiting for start, outputs held from reset
// RUN   | sweeping vectors, holding each for HOLD cycles
// DONE  | sweep complete, signature and pass frozen until next start
module exhaustive_bist #(
  parameter int                N_IN      = 4,
  parameter int                N_OUT     = 2,
  parameter int                HOLD      = 1,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h8016,
  parameter logic [MISR_W-1:0] SEED      = '0,
  parameter logic [MISR_W-1:0] GOLDEN    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  resp_in,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [MISR_W-1:0]   sig_q, sig_d;
  logic                pass_q, pass_d;
  logic [MISR_W-1:0]   resp_ext;
  logic [MISR_W-1:0]   misr_next;
  logic                sample_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      sig_q   <= SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    resp_ext = '0;
    resp_ext[N_OUT-1:0] = resp_in;
    sample_c  = (state_q == RUN) && (hold_q == HOLD_LAST);
    misr_next = {sig_q[MISR_W-2:0], 1'b0}
              ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
              ^ resp_ext;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          hold_d  = '0;
          sig_d   = SEED;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately ignored here so a sweep can never be disturbed
        if (sample_c) begin
          sig_d  = misr_next;
          hold_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            pass_d  = (misr_next == GOLDEN);
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_out   = vec_q;
  assign sample    = sample_c;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_exhaustive_bist.sv
// Directed bench for exhaustive_bist: several parameterisations checked against
// hand-computed vector sequences, busy lengths and MISR signatures.
module tb_exhaustive_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference block under test: f = a&b | c
  function automatic logic f_ref(input logic [3:0] v);
    return (v[0] & v[1]) | v[2];
  endfunction

  // u1: defaults, HOLD=1, GOLDEN=0
  logic        start1 = 1'b0, r1_f = 1'b0;
  logic [3:0]  vec1;
  logic [1:0]  resp1;
  logic        sample1, busy1, done1, pass1;
  logic [15:0] sig1;
  assign resp1 = r1_f ? {1'b0, f_ref(vec1)} : 2'b00;

  exhaustive_bist u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1), .resp_in(resp1),
    .sample(sample1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  // u2: HOLD=3, glitches injected outside sample cycles
  logic        start2 = 1'b0;
  logic [3:0]  vec2;
  logic [1:0]  resp2, glitch;
  logic        sample2, busy2, done2, pass2;
  logic [15:0] sig2;
  always @(posedge clk) glitch <= 2'($urandom);
  assign resp2 = sample2 ? {1'b0, f_ref(vec2)} : glitch;

  exhaustive_bist #(.HOLD(3), .GOLDEN(16'h1F1F)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec2), .resp_in(resp2),
    .sample(sample2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

  // u3: golden = hand-computed fault-free signature, optional stuck-at-1
  logic        start3 = 1'b0, stuck = 1'b0;
  logic [3:0]  vec3;
  logic [0:0]  resp3;
  logic        sample3, busy3, done3, pass3;
  logic [15:0] sig3;
  assign resp3 = stuck ? 1'b1 : f_ref(vec3);

  exhaustive_bist #(.N_OUT(1), .GOLDEN(16'h1F1F)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec_out(vec3), .resp_in(resp3),
    .sample(sample3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

  // u4: 4-bit MISR x^4+x+1, SEED=1, zero response -> x^16 mod p = x = 4'h2
  logic        start4 = 1'b0;
  logic [3:0]  vec4;
  logic [0:0]  resp4;
  logic        sample4, busy4, done4, pass4;
  logic [3:0]  sig4;
  assign resp4 = 1'b0;

  exhaustive_bist #(.N_OUT(1), .MISR_W(4), .MISR_POLY(4'h3), .SEED(4'h1), .GOLDEN(4'h2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .vec_out(vec4), .resp_in(resp4),
    .sample(sample4), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

  int cnt;

  initial begin
    #12;
    chk("rst_vec", 32'(vec1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_sample", 32'(sample1), 0);
    chk("rst_sig4_seed", 32'(sig4), 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy1), 0);

    // 1: HOLD=1, resp 0
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 100) begin
      chk("t1_vec", 32'(vec1), 32'(cnt));
      chk("t1_sample", 32'(sample1), 1);
      cnt++; @(negedge clk);
    end
    chk("t1_busy_len", 32'(cnt), 16);
    chk("t1_done", 32'(done1), 1);
    chk("t1_pass", 32'(pass1), 1);
    chk("t1_sig", 32'(sig1), 0);
    chk("t1_vec_last", 32'(vec1), 15);
    chk("t1_sample_done", 32'(sample1), 0);

    // 2: HOLD=3 with glitching resp outside sample cycles
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    cnt = 0;
    while (busy2 && cnt < 200) begin
      chk("t2_vec", 32'(vec2), 32'(cnt / 3));
      chk("t2_sample", 32'(sample2), 32'(cnt % 3 == 2));
      cnt++; @(negedge clk);
    end
    chk("t2_busy_len", 32'(cnt), 48);
    chk("t2_done", 32'(done2), 1);
    chk("t2_sig", 32'(sig2), 32'h1F1F);
    chk("t2_pass", 32'(pass2), 1);

    // 3a: record run of f on u1 (GOLDEN=0 -> fails, signature is S)
    r1_f = 1'b1;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("t3_rec_sig", 32'(sig1), 32'h1F1F);
    chk("t3_rec_pass", 32'(pass1), 0);
    r1_f = 1'b0;

    // 3b: u3 with GOLDEN=S passes
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    cnt = 0;
    while (busy3 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("t3_len", 32'(cnt), 16);
    chk("t3_sig", 32'(sig3), 32'h1F1F);
    chk("t3_pass", 32'(pass3), 1);

    // 6: restart from DONE clears done/pass, reloads SEED, same result
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    chk("t6_done_clr", 32'(done3), 0);
    chk("t6_pass_clr", 32'(pass3), 0);
    chk("t6_sig_seed", 32'(sig3), 0);
    chk("t6_busy", 32'(busy3), 1);
    chk("t6_vec0", 32'(vec3), 0);
    cnt = 0;
    while (busy3 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("t6_len", 32'(cnt), 16);
    chk("t6_sig", 32'(sig3), 32'h1F1F);
    chk("t6_pass", 32'(pass3), 1);

    // 3c: stuck-at-1 on resp_in[0]
    stuck = 1'b1;
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    cnt = 0;
    while (busy3 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("t3_stuck_sig", 32'(sig3), 32'hFFFF);
    chk("t3_stuck_pass", 32'(pass3), 0);
    stuck = 1'b0;

    // feedback path: u4
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    chk("fb_sig_seed", 32'(sig4), 1);
    cnt = 0;
    while (busy4 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("fb_len", 32'(cnt), 16);
    chk("fb_sig", 32'(sig4), 2);
    chk("fb_pass", 32'(pass4), 1);

    // 5: start mid-sweep is ignored
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 100) begin
      chk("t5_vec", 32'(vec1), 32'(cnt));
      start1 = (vec1 == 4'd5);
      cnt++; @(negedge clk);
      start1 = 1'b0;
    end
    chk("t5_len", 32'(cnt), 16);
    chk("t5_done", 32'(done1), 1);

    // 4: async reset while vec_out=7
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    cnt = 0;
    while (vec1 != 4'd7 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("t4_reach7", 32'(vec1), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_vec", 32'(vec1), 0);
    chk("t4_busy", 32'(busy1), 0);
    chk("t4_done", 32'(done1), 0);
    chk("t4_sig", 32'(sig1), 0);
    chk("t4_sig4_seed", 32'(sig4), 1);
    chk("t4_done4", 32'(done4), 0);
    chk("t4_pass4", 32'(pass4), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_idle_busy", 32'(busy1), 0);
    chk("t4_idle_vec", 32'(vec1), 0);
    chk("t4_idle_done", 32'(done1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
